pwm_ramp_ctrl: RTL and testbench
================================

PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 28: width of period/duty values.
REQ-002 SHALL have parameter STEP, default 1: duty change per applied PWM period while ramping.
REQ-003 SHALL have parameter PERIOD_RST, default 50000000: PERIOD_OUT value after reset.
REQ-004 SHALL have port CLK  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port RST  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port WR_PERIOD  in  1  one-cycle strobe; load WR_DATA into the period shadow.
REQ-007 SHALL have port WR_DUTY  in  1  one-cycle strobe; load WR_DATA into the duty target.
REQ-008 SHALL have port WR_DATA  in  WIDTH  write data from the CPU PIO.
REQ-009 SHALL have port PERIOD_END  in  1  one-cycle pulse from downstream PWM counter at its wrap (counter clear).
REQ-010 SHALL have port PERIOD_OUT  out  WIDTH  active period fed to the PWM counter.
REQ-011 SHALL have port DUTY_OUT  out  WIDTH  active compare value fed to the PWM counter.
REQ-012 SHALL have port BUSY  out  1  high while DUTY_OUT differs from the effective target.

Function
REQ-013 SHALL hold registers: period_shadow, duty_target, PERIOD_OUT, DUTY_OUT, state.
REQ-014 SHALL change PERIOD_OUT and DUTY_OUT only in the cycle after a PERIOD_END pulse (glitch-free update at PWM wrap).
REQ-015 SHALL store WR_DATA in period_shadow on WR_PERIOD; value 0 stored as 1.
REQ-016 SHALL store WR_DATA in duty_target on WR_DUTY.
REQ-017 SHALL give WR_PERIOD priority when WR_PERIOD and WR_DUTY are both high; WR_DUTY ignored that cycle.
REQ-018 SHALL, when a write coincides with PERIOD_END, apply the pre-write shadow/target at that PERIOD_END; new value takes effect at the following PERIOD_END.
REQ-019 SHALL on PERIOD_END: PERIOD_OUT <= period_shadow; eff_target = min(duty_target, period_shadow).
REQ-020 SHALL on PERIOD_END clamp DUTY_OUT to period_shadow at once if DUTY_OUT > period_shadow, before any stepping.
REQ-021 SHALL run FSM states IDLE, RAMP_UP, RAMP_DOWN, evaluated on each PERIOD_END.
REQ-022 SHALL transition: DUTY_OUT < eff_target -> RAMP_UP; DUTY_OUT > eff_target -> RAMP_DOWN; equal -> IDLE.
REQ-023 SHALL in RAMP_UP set DUTY_OUT <= min(DUTY_OUT+STEP, eff_target); in RAMP_DOWN DUTY_OUT <= max(DUTY_OUT-STEP, eff_target); no overshoot, no wrap (WIDTH+1-bit arithmetic).
REQ-024 SHALL recompute direction at every PERIOD_END, so a target write mid-ramp reverses or ends the ramp at the next wrap.
REQ-025 SHALL drive BUSY = (state != IDLE), registered, valid the cycle after PERIOD_END.
REQ-026 SHALL hold all outputs constant when PERIOD_END never pulses.

Reset
REQ-027 SHALL on RST asynchronously set PERIOD_OUT = period_shadow = PERIOD_RST, DUTY_OUT = duty_target = 0, state = IDLE, BUSY = 0.
REQ-028 SHALL, on RST mid-ramp, abandon the ramp; first PERIOD_END after release sees IDLE with target 0.
REQ-029 SHALL ignore WR_* and PERIOD_END while RST is high.

Configuration
REQ-030 SHALL with macro PWM_RAMP_SLEW_EN defined implement REQ-021..REQ-025 stepping.
REQ-031 SHALL without PWM_RAMP_SLEW_EN load DUTY_OUT <= eff_target at each PERIOD_END, tie BUSY to 0, omit the FSM.

Verification
REQ-032 SHALL cover: reset, no writes -> PERIOD_OUT=50000000, DUTY_OUT=0, BUSY=0.
REQ-033 SHALL cover: STEP=1, period 10, WR_DUTY 4, 5 PERIOD_END pulses -> DUTY_OUT 0,1,2,3,4,4; BUSY low after 4th.
REQ-034 SHALL cover: STEP=3, period 10, duty at 0, target 7 -> DUTY_OUT 3,6,7 (no overshoot); then target 2 -> 4,2.
REQ-035 SHALL cover: DUTY_OUT=8, WR_PERIOD 5 then PERIOD_END -> PERIOD_OUT=5, DUTY_OUT=5 same cycle; WR_PERIOD 0 -> PERIOD_OUT=1.
REQ-036 SHALL cover: WR_DUTY 9 in same cycle as PERIOD_END (target was 2, duty 2) -> DUTY_OUT stays 2; steps to 3 at next PERIOD_END.
REQ-037 SHALL cover: RST pulse mid-ramp (duty 5, target 9) -> DUTY_OUT=0, BUSY=0 asynchronously; without PWM_RAMP_SLEW_EN, target 9 -> DUTY_OUT=9 on first PERIOD_END.

Source files
------------

// File: rtl/pwm_ramp_ctrl_if.sv
// Bus between the CPU PIO / PWM counter and pwm_ramp_ctrl.
// The CPU side writes period and duty. The counter side supplies the wrap pulse and takes back the active period and duty.
interface pwm_ramp_ctrl_if #(
   parameter int WIDTH = 28
);
   logic             WR_PERIOD;
   logic             WR_DUTY;
   logic [WIDTH-1:0] WR_DATA;
   logic             PERIOD_END;
   logic [WIDTH-1:0] PERIOD_OUT;
   logic [WIDTH-1:0] DUTY_OUT;
   logic             BUSY;

   modport master (
      output WR_PERIOD,
      output WR_DUTY,
      output WR_DATA,
      output PERIOD_END,
      input  PERIOD_OUT,
      input  DUTY_OUT,
      input  BUSY
   );

   modport slave (
      input  WR_PERIOD,
      input  WR_DUTY,
      input  WR_DATA,
      input  PERIOD_END,
      output PERIOD_OUT,
      output DUTY_OUT,
      output BUSY
   );
endinterface

// File: rtl/pwm_ramp_ctrl.sv
// PWM period/duty controller that updates the outputs only at the PWM wrap, so they change without glitches.
// With PWM_RAMP_SLEW_EN defined, duty moves toward its target by STEP per wrap. Otherwise duty jumps to the target.
module pwm_ramp_ctrl #(
   parameter int WIDTH      = 28,
   parameter int STEP       = 1,
   parameter int PERIOD_RST = 50000000
) (
   input  logic           CLK,
   input  logic           RST,
   pwm_ramp_ctrl_if.slave bus
);

   localparam logic [WIDTH-1:0] PERIOD_RST_W = WIDTH'(PERIOD_RST);
   localparam logic [WIDTH-1:0] ZERO_W       = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE_W        = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] period_shadow_r;
   logic [WIDTH-1:0] duty_target_r;
   logic [WIDTH-1:0] period_out_r;
   logic [WIDTH-1:0] duty_out_r;

   logic [WIDTH-1:0] eff_target_s;
   logic [WIDTH-1:0] wr_period_val_s;
   logic [WIDTH-1:0] duty_next_s;
   logic             busy_s;

   // A zero period cannot be counted, so it is stored as 1. Duty is limited to the period it will run under.
   always_comb begin
      eff_target_s    = ZERO_W;
      wr_period_val_s = ZERO_W;
      if (duty_target_r < period_shadow_r) begin
         eff_target_s = duty_target_r;
      end else begin
         eff_target_s = period_shadow_r;
      end
      if (bus.WR_DATA == ZERO_W) begin
         wr_period_val_s = ONE_W;
      end else begin
         wr_period_val_s = bus.WR_DATA;
      end
   end

   // CPU-visible shadow registers; a period write wins over a simultaneous duty write
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         period_shadow_r <= PERIOD_RST_W;
         duty_target_r   <= ZERO_W;
      end else if (bus.WR_PERIOD) begin
         period_shadow_r <= wr_period_val_s;
         duty_target_r   <= duty_target_r;
      end else if (bus.WR_DUTY) begin
         period_shadow_r <= period_shadow_r;
         duty_target_r   <= bus.WR_DATA;
      end else begin
         period_shadow_r <= period_shadow_r;
         duty_target_r   <= duty_target_r;
      end
   end

`ifdef PWM_RAMP_SLEW_EN
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RAMP_UP   = 2'd1,
      RAMP_DOWN = 2'd2
   } state_t;

   localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);
   localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

   state_t           state_r;
   state_t           state_next_s;
   state_t           dir_s;
   logic             busy_r;
   logic [WIDTH-1:0] duty_clamp_s;
   logic [WIDTH-1:0] duty_step_s;
   logic [WIDTH-1:0] dn_diff_s;
   logic [WIDTH:0]   up_sum_s;
   logic [WIDTH:0]   dn_floor_s;

   // Clamp into the new period first, then step toward the target. The extra sum bit keeps a step from wrapping.
   always_comb begin
      duty_clamp_s = duty_out_r;
      duty_step_s  = duty_out_r;
      dir_s        = IDLE;
      state_next_s = state_r;
      duty_next_s  = duty_out_r;
      if (duty_out_r > period_shadow_r) begin
         duty_clamp_s = period_shadow_r;
      end else begin
         duty_clamp_s = duty_out_r;
      end
      up_sum_s   = {1'b0, duty_clamp_s} + STEP_X;
      dn_floor_s = {1'b0, eff_target_s} + STEP_X;
      dn_diff_s  = duty_clamp_s - STEP_W;
      if (duty_clamp_s < eff_target_s) begin
         dir_s = RAMP_UP;
      end else if (duty_clamp_s > eff_target_s) begin
         dir_s = RAMP_DOWN;
      end else begin
         dir_s = IDLE;
      end
      case (dir_s)
         RAMP_UP: begin
            if (up_sum_s >= {1'b0, eff_target_s}) begin
               duty_step_s = eff_target_s;
            end else begin
               duty_step_s = up_sum_s[WIDTH-1:0];
            end
         end
         RAMP_DOWN: begin
            if ({1'b0, duty_clamp_s} <= dn_floor_s) begin
               duty_step_s = eff_target_s;
            end else begin
               duty_step_s = dn_diff_s;
            end
         end
         default: begin
            duty_step_s = duty_clamp_s;
         end
      endcase
      // The state records whether a ramp is still pending after this wrap, and BUSY is derived from it.
      if (bus.PERIOD_END) begin
         duty_next_s = duty_step_s;
         if (duty_step_s < eff_target_s) begin
            state_next_s = RAMP_UP;
         end else if (duty_step_s > eff_target_s) begin
            state_next_s = RAMP_DOWN;
         end else begin
            state_next_s = IDLE;
         end
      end else begin
         duty_next_s  = duty_out_r;
         state_next_s = state_r;
      end
   end

   // Ramp state register and registered BUSY flag
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_r <= IDLE;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_next_s;
         busy_r  <= (state_next_s != IDLE);
      end
   end

   assign busy_s = busy_r;
`else
   // Without slew limiting, the duty jumps straight to the target at each wrap.
   always_comb begin
      duty_next_s = duty_out_r;
      if (bus.PERIOD_END) begin
         duty_next_s = eff_target_s;
      end else begin
         duty_next_s = duty_out_r;
      end
   end

   assign busy_s = 1'b0;
`endif

   // Active values seen by the PWM counter; they change only at its wrap
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         period_out_r <= PERIOD_RST_W;
         duty_out_r   <= ZERO_W;
      end else if (bus.PERIOD_END) begin
         period_out_r <= period_shadow_r;
         duty_out_r   <= duty_next_s;
      end else begin
         period_out_r <= period_out_r;
         duty_out_r   <= duty_out_r;
      end
   end

   assign bus.PERIOD_OUT = period_out_r;
   assign bus.DUTY_OUT   = duty_out_r;
   assign bus.BUSY       = busy_s;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Self-checking bench for pwm_ramp_ctrl with two instances (STEP=1 and STEP=3) driven by identical stimulus.
// A behavioural model tracks the period, duty and busy flag at each wrap.
`timescale 1ns/1ps
module tb_pwm_ramp_ctrl;
   localparam int W = 28;
   localparam longint PRST = 50000000;
`ifdef PWM_RAMP_SLEW_EN
   localparam bit SLEW = 1'b1;
`else
   localparam bit SLEW = 1'b0;
`endif

   logic CLK = 1'b0;
   logic RST = 1'b1;
   int   total = 0;
   int   bad   = 0;

   pwm_ramp_ctrl_if #(.WIDTH(W)) if1 ();
   pwm_ramp_ctrl_if #(.WIDTH(W)) if3 ();

   pwm_ramp_ctrl #(.WIDTH(W), .STEP(1), .PERIOD_RST(50000000)) u_dut1 (.CLK(CLK), .RST(RST), .bus(if1));
   pwm_ramp_ctrl #(.WIDTH(W), .STEP(3), .PERIOD_RST(50000000)) u_dut3 (.CLK(CLK), .RST(RST), .bus(if3));

   always #5 CLK = ~CLK;

   // reference model state, index 0 -> STEP 1, index 1 -> STEP 3
   longint m_shadow [2];
   longint m_target [2];
   longint m_period [2];
   longint m_duty   [2];
   bit     m_busy   [2];
   longint step_of  [2] = '{1, 3};

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_shadow[k] = PRST; m_target[k] = 0; m_period[k] = PRST; m_duty[k] = 0; m_busy[k] = 1'b0;
      end
   endtask

   task automatic model_edge(bit wp, bit wd, longint data, bit pe);
      longint eff, d;
      for (int k = 0; k < 2; k++) begin
         if (pe) begin
            eff = (m_target[k] < m_shadow[k]) ? m_target[k] : m_shadow[k];
            d   = (m_duty[k] > m_shadow[k]) ? m_shadow[k] : m_duty[k];
            if (SLEW) begin
               if (d < eff) d = (d + step_of[k] > eff) ? eff : d + step_of[k];
               else if (d > eff) d = (d - step_of[k] < eff) ? eff : d - step_of[k];
            end else begin
               d = eff;
            end
            m_period[k] = m_shadow[k];
            m_duty[k]   = d;
            m_busy[k]   = SLEW && (d != eff);
         end
         if (wp) m_shadow[k] = (data == 0) ? 1 : data;
         else if (wd) m_target[k] = data;
      end
   endtask

   task automatic drive(bit wp, bit wd, logic [W-1:0] data, bit pe);
      if1.WR_PERIOD = wp; if1.WR_DUTY = wd; if1.WR_DATA = data; if1.PERIOD_END = pe;
      if3.WR_PERIOD = wp; if3.WR_DUTY = wd; if3.WR_DATA = data; if3.PERIOD_END = pe;
   endtask

   // one clock with the given inputs; ends 1 ns after the edge with inputs idle
   task automatic tick(bit wp, bit wd, logic [W-1:0] data, bit pe);
      drive(wp, wd, data, pe);
      @(posedge CLK);
      if (!RST) model_edge(wp, wd, longint'(data), pe);
      #1;
      drive(1'b0, 1'b0, '0, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge CLK); RST = 1'b1;
      @(posedge CLK); #1; model_reset();
      @(negedge CLK); RST = 1'b0;
   endtask

   function automatic logic [2*W:0] obs(int k);
      if (k == 0) return {if1.PERIOD_OUT, if1.DUTY_OUT, if1.BUSY};
      else        return {if3.PERIOD_OUT, if3.DUTY_OUT, if3.BUSY};
   endfunction

   function automatic logic [2*W:0] expv(int k);
      return {W'(m_period[k]), W'(m_duty[k]), m_busy[k]};
   endfunction

   function automatic string fmt(logic [2*W:0] v);
      return $sformatf("period=%0d duty=%0d busy=%0d", v[2*W:W+1], v[W:1], v[0]);
   endfunction

   task automatic test_reset();
      logic [2*W:0] o, e;
      drive(1'b0, 1'b0, '0, 1'b0);
      RST = 1'b1;
      repeat (2) @(posedge CLK);
      #1; model_reset();
      total++;
      if ({if1.PERIOD_OUT, if1.DUTY_OUT, if1.BUSY} !== {28'd50000000, 28'd0, 1'b0}) begin
         bad++; $display("FAIL reset_const got %s want period=50000000 duty=0 busy=0", fmt(obs(0)));
      end
      // writes and wrap pulses while reset is held are ignored
      drive(1'b1, 1'b1, 28'd7, 1'b1);
      @(posedge CLK); #1;
      drive(1'b0, 1'b0, '0, 1'b0);
      @(negedge CLK); RST = 1'b0;
      tick(1'b0, 1'b0, '0, 1'b1);
      for (int k = 0; k < 2; k++) begin
         o = obs(k); e = expv(k); total++;
         if (o !== e) begin bad++; $display("FAIL reset_wrap dut%0d got %s want %s", k, fmt(o), fmt(e)); end
      end
   endtask

   task automatic test_ramp_step1();
      logic [2*W:0] o, e;
      longint ed [5] = SLEW ? '{1, 2, 3, 4, 4} : '{4, 4, 4, 4, 4};
      bit     eb [5] = SLEW ? '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0} : '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      do_reset();
      tick(1'b1, 1'b0, 28'd10, 1'b0);
      tick(1'b0, 1'b1, 28'd4, 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick(1'b0, 1'b0, '0, 1'b1);
         total++;
         if (if1.DUTY_OUT !== W'(ed[i]) || if1.BUSY !== eb[i] || if1.PERIOD_OUT !== 28'd10) begin
            bad++; $display("FAIL ramp1_seq%0d got %s want duty=%0d busy=%0d", i, fmt(obs(0)), ed[i], eb[i]);
         end
         repeat (2) tick(1'b0, 1'b0, '0, 1'b0);
         for (int k = 0; k < 2; k++) begin
            o = obs(k); e = expv(k); total++;
            if (o !== e) begin bad++; $display("FAIL ramp1_hold dut%0d got %s want %s", k, fmt(o), fmt(e)); end
         end
      end
   endtask

   task automatic test_step3();
      logic [2*W:0] o, e;
      longint ed [5] = SLEW ? '{3, 6, 7, 4, 2} : '{7, 7, 7, 2, 2};
      do_reset();
      tick(1'b1, 1'b0, 28'd10, 1'b0);
      tick(1'b0, 1'b1, 28'd7, 1'b0);
      for (int i = 0; i < 5; i++) begin
         if (i == 3) tick(1'b0, 1'b1, 28'd2, 1'b0);
         tick(1'b0, 1'b0, '0, 1'b1);
         total++;
         if (if3.DUTY_OUT !== W'(ed[i])) begin
            bad++; $display("FAIL step3_seq%0d got %s want duty=%0d", i, fmt(obs(1)), ed[i]);
         end
         for (int k = 0; k < 2; k++) begin
            o = obs(k); e = expv(k); total++;
            if (o !== e) begin bad++; $display("FAIL step3_model dut%0d got %s want %s", k, fmt(o), fmt(e)); end
         end
      end
   endtask

   task automatic test_clamp();
      do_reset();
      tick(1'b1, 1'b0, 28'd10, 1'b0);
      tick(1'b0, 1'b1, 28'd8, 1'b0);
      repeat (9) tick(1'b0, 1'b0, '0, 1'b1);
      total++;
      if (if1.DUTY_OUT !== 28'd8) begin bad++; $display("FAIL clamp_pre got %s want duty=8", fmt(obs(0))); end
      tick(1'b1, 1'b0, 28'd5, 1'b0);
      tick(1'b0, 1'b0, '0, 1'b1);
      total++;
      if ({if1.PERIOD_OUT, if1.DUTY_OUT, if1.BUSY} !== {28'd5, 28'd5, 1'b0}) begin
         bad++; $display("FAIL clamp_5 got %s want period=5 duty=5 busy=0", fmt(obs(0)));
      end
      tick(1'b1, 1'b0, 28'd0, 1'b0);
      tick(1'b0, 1'b0, '0, 1'b1);
      for (int k = 0; k < 2; k++) begin
         total++;
         if (obs(k) !== {28'd1, 28'd1, 1'b0}) begin
            bad++; $display("FAIL clamp_zero dut%0d got %s want period=1 duty=1 busy=0", k, fmt(obs(k)));
         end
      end
   endtask

   task automatic test_coincident();
      logic [2*W:0] o, e;
      do_reset();
      tick(1'b1, 1'b0, 28'd10, 1'b0);
      tick(1'b0, 1'b1, 28'd2, 1'b0);
      repeat (3) tick(1'b0, 1'b0, '0, 1'b1);
      tick(1'b0, 1'b1, 28'd9, 1'b1);
      total++;
      if (if1.DUTY_OUT !== 28'd2) begin bad++; $display("FAIL coinc_same got %s want duty=2", fmt(obs(0))); end
      tick(1'b0, 1'b0, '0, 1'b1);
      total++;
      if (if1.DUTY_OUT !== (SLEW ? 28'd3 : 28'd9)) begin
         bad++; $display("FAIL coinc_next got %s want duty=%0d", fmt(obs(0)), SLEW ? 3 : 9);
      end
      // both strobes at once: period 12 is taken, duty write of 12 is dropped
      tick(1'b1, 1'b1, 28'd12, 1'b0);
      repeat (10) tick(1'b0, 1'b0, '0, 1'b1);
      total++;
      if ({if1.PERIOD_OUT, if1.DUTY_OUT, if1.BUSY} !== {28'd12, 28'd9, 1'b0}) begin
         bad++; $display("FAIL priority got %s want period=12 duty=9 busy=0", fmt(obs(0)));
      end
      for (int k = 0; k < 2; k++) begin
         o = obs(k); e = expv(k); total++;
         if (o !== e) begin bad++; $display("FAIL coinc_model dut%0d got %s want %s", k, fmt(o), fmt(e)); end
      end
   endtask

   task automatic test_reset_mid_ramp();
      do_reset();
      tick(1'b1, 1'b0, 28'd10, 1'b0);
      tick(1'b0, 1'b1, 28'd9, 1'b0);
      repeat (5) tick(1'b0, 1'b0, '0, 1'b1);
      total++;
      if (if1.DUTY_OUT !== (SLEW ? 28'd5 : 28'd9) || if1.BUSY !== SLEW) begin
         bad++; $display("FAIL mid_pre got %s want duty=%0d busy=%0d", fmt(obs(0)), SLEW ? 5 : 9, SLEW);
      end
      @(posedge CLK); #3;
      RST = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         total++;
         if (obs(k) !== {28'd50000000, 28'd0, 1'b0}) begin
            bad++; $display("FAIL mid_async dut%0d got %s want period=50000000 duty=0 busy=0", k, fmt(obs(k)));
         end
      end
      model_reset();
      @(negedge CLK); RST = 1'b0;
      tick(1'b0, 1'b0, '0, 1'b1);
      total++;
      if ({if1.DUTY_OUT, if1.BUSY} !== {28'd0, 1'b0}) begin
         bad++; $display("FAIL mid_first_wrap got %s want duty=0 busy=0", fmt(obs(0)));
      end
      tick(1'b0, 1'b1, 28'd9, 1'b0);
      tick(1'b0, 1'b0, '0, 1'b1);
      total++;
      if (if1.DUTY_OUT !== (SLEW ? 28'd1 : 28'd9) || if3.DUTY_OUT !== (SLEW ? 28'd3 : 28'd9)) begin
         bad++; $display("FAIL mid_retarget got %s / %s want duty=%0d / %0d", fmt(obs(0)), fmt(obs(1)),
                         SLEW ? 1 : 9, SLEW ? 3 : 9);
      end
   endtask

   task automatic test_random();
      logic [2*W:0] o, e;
      logic [W-1:0] data;
      int r;
      bit wp, wd, pe;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         r  = int'($urandom_range(0, 19));
         wp = (r == 0) || (r == 3);
         wd = (r == 1) || (r == 2) || (r == 3);
         pe = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 15) == 0) data = W'($urandom);
         else data = W'($urandom_range(0, 40));
         tick(wp, wd, data, pe);
         for (int k = 0; k < 2; k++) begin
            o = obs(k); e = expv(k); total++;
            if (o !== e) begin bad++; $display("FAIL random%0d dut%0d got %s want %s", i, k, fmt(o), fmt(e)); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_ramp_step1();
      test_step3();
      test_clamp();
      test_coincident();
      test_reset_mid_ramp();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
